// File: rtl/pts_byte_sequencer.sv
// Handshake controller for the 128-to-8 parallel-to-serial byte shifter.
// Loads one block on the upstream handshake, then releases one word per downstream accept.
module pts_byte_sequencer #(
  parameter int NUM_BITS = 128,
  parameter int NUM_OUT = 8,
  localparam int NUM_WORDS = NUM_BITS / NUM_OUT,
  localparam int CNT_W = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             abort,
  output logic             load_enable,
  output logic             shift_enable,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] word_idx,
  output logic             word_last,
  output logic             blk_done,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             idle_s;
  logic             send_s;
  logic             last_s;

  // Every output is forced low while rst is held.
  assign idle_s       = ~rst & (state_r == IDLE);
  assign send_s       = ~rst & (state_r == SEND);
  assign last_s       = (cnt_r == LAST_IDX);

  assign blk_ready    = idle_s & ~abort;
  assign load_enable  = blk_valid & blk_ready;
  assign word_valid   = send_s;
  assign busy         = send_s;
  assign word_idx     = send_s ? cnt_r : {CNT_W{1'b0}};
  assign word_last    = send_s & last_s;
  // Abort suppresses the shift so a discarded block never advances the shifter.
  assign shift_enable = word_valid & word_ready & ~abort;
  assign blk_done     = done_r & ~rst;

  // Next-state, word counter and completion-pulse logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_enable) begin
          state_nxt_s = SEND;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (shift_enable) begin
          if (last_s) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            done_nxt_s  = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_pts_byte_sequencer.sv
// Directed self-checking bench for pts_byte_sequencer, with a behavioural
// byte shifter driven by load_enable/shift_enable to check word order.
module tb_pts_byte_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       blk_valid;
  logic       blk_ready;
  logic       abort;
  logic       load_enable;
  logic       shift_enable;
  logic       word_valid;
  logic       word_ready;
  logic [3:0] word_idx;
  logic       word_last;
  logic       blk_done;
  logic       busy;

  logic [127:0] pin;
  logic [127:0] sh;
  logic [7:0]   word_q;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK2 = 128'h00770000_00000000_00000000_000000C3;

  always #5 clk = ~clk;

  pts_byte_sequencer dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .abort(abort), .load_enable(load_enable), .shift_enable(shift_enable),
    .word_valid(word_valid), .word_ready(word_ready), .word_idx(word_idx),
    .word_last(word_last), .blk_done(blk_done), .busy(busy)
  );

  // Behavioural stand-in for the byte shifter.
  always_ff @(posedge clk) begin
    if (load_enable) sh <= pin;
    else if (shift_enable) sh <= {sh[119:0], 8'h00};
  end
  assign word_q = sh[127:120];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_blk(input logic [127:0] b);
    pin = b; blk_valid = 1'b1; word_ready = 1'b1; abort = 1'b0;
    @(negedge clk);
    chk("load_blk_ready", blk_ready, 1'b1);
    chk("load_enable", load_enable, 1'b1);
    chk("load_no_shift", shift_enable, 1'b0);
    next_cycle();
    blk_valid = 1'b0;
  endtask

  task automatic stream(input logic [127:0] b, input int from, input int to);
    logic [127:0] tmp;
    for (int k = from; k <= to; k++) begin
      word_ready = 1'b1; abort = 1'b0;
      @(negedge clk);
      tmp = b << (8 * k);
      chk("st_valid", word_valid, 1'b1);
      chk("st_idx", word_idx, k[3:0]);
      chk("st_word", word_q, tmp[127:120]);
      chk("st_last", word_last, (k == 15));
      chk("st_shift", shift_enable, 1'b1);
      chk("st_blk_ready", blk_ready, 1'b0);
      chk("st_load", load_enable, 1'b0);
      next_cycle();
    end
  endtask

  initial begin
    int accepts;
    int c;
    logic [127:0] tmp;
    rst = 1'b1; blk_valid = 1'b1; abort = 1'b0; word_ready = 1'b1; pin = BLK1;

    // Reset: all outputs low even with blk_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {blk_ready, load_enable, shift_enable, word_valid, busy,
                       blk_done, word_last, word_idx}, 11'h000);
      next_cycle();
    end
    rst = 1'b0; blk_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", blk_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_wvalid", word_valid, 1'b0);
    next_cycle();

    // Single block, ready held high.
    load_blk(BLK1);
    stream(BLK1, 0, 15);
    @(negedge clk);
    chk("done_pulse", blk_done, 1'b1);
    chk("done_ready", blk_ready, 1'b1);
    chk("done_wvalid", word_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("done_once", blk_done, 1'b0);
    next_cycle();

    // Backpressure with ready pattern 1,0,0,1,0,0,...
    load_blk(BLK1);
    accepts = 0;
    c = 0;
    while (accepts < 16 && c < 80) begin
      word_ready = (c % 3 == 0);
      @(negedge clk);
      tmp = BLK1 << (8 * accepts);
      chk("bp_valid", word_valid, 1'b1);
      chk("bp_idx", word_idx, accepts[3:0]);
      chk("bp_word", word_q, tmp[127:120]);
      chk("bp_shift", shift_enable, word_ready);
      chk("bp_done", blk_done, 1'b0);
      if (word_ready) accepts++;
      c++;
      next_cycle();
    end
    chk("bp_accepts", accepts, 16);
    word_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_pulse", blk_done, 1'b1);
    next_cycle();

    // Blocked upload: blk_valid held during SEND.
    load_blk(BLK1);
    blk_valid = 1'b1; pin = BLK2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("blk_ready_send", blk_ready, 1'b0);
      chk("blk_load_send", load_enable, 1'b0);
      chk("blk_idx", word_idx, k[3:0]);
      next_cycle();
    end
    @(negedge clk);
    chk("blk_done2", blk_done, 1'b1);
    chk("blk_reload", load_enable, 1'b1);
    next_cycle();
    blk_valid = 1'b0;
    stream(BLK2, 0, 15);
    @(negedge clk);
    chk("blk2_done", blk_done, 1'b1);
    next_cycle();

    // Abort at word 5, then abort in IDLE blocks handshake.
    load_blk(BLK1);
    stream(BLK1, 0, 4);
    abort = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    chk("ab_idx", word_idx, 4'd5);
    chk("ab_shift", shift_enable, 1'b0);
    next_cycle();
    blk_valid = 1'b1;
    @(negedge clk);
    chk("ab_idle_wvalid", word_valid, 1'b0);
    chk("ab_idle_busy", busy, 1'b0);
    chk("ab_no_done", blk_done, 1'b0);
    chk("ab_idle_ready", blk_ready, 1'b0);
    chk("ab_idle_load", load_enable, 1'b0);
    next_cycle();
    abort = 1'b0; blk_valid = 1'b0;
    @(negedge clk);
    chk("ab_no_done2", blk_done, 1'b0);
    chk("ab_ready_back", blk_ready, 1'b1);
    next_cycle();
    load_blk(BLK1);
    stream(BLK1, 0, 15);
    next_cycle();

    // Reset mid-block at word 9.
    load_blk(BLK1);
    stream(BLK1, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outs", {blk_ready, load_enable, shift_enable, word_valid, busy,
                    blk_done, word_last, word_idx}, 11'h000);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_ready", blk_ready, 1'b1);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", blk_done, 1'b0);
    next_cycle();

    // Abort coinciding with the final accept.
    load_blk(BLK1);
    stream(BLK1, 0, 14);
    abort = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    chk("af_last", word_last, 1'b1);
    chk("af_shift", shift_enable, 1'b0);
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    chk("af_wvalid", word_valid, 1'b0);
    chk("af_done", blk_done, 1'b0);
    chk("af_ready", blk_ready, 1'b1);
    next_cycle();
    load_blk(BLK2);
    @(negedge clk);
    chk("af_restart_idx", word_idx, 4'd0);
    chk("af_restart_word", word_q, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
